// File: rtl/dmem_responder.sv
// Data-memory responder for the Memory stage: fixed-latency load/store with byte lanes and a stall strobe.
// Optional feature: define DMEM_POSTED_WRITE_EN to complete stores one cycle after acceptance.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic        MByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadData,
  output logic        MemReadyM,
  output logic        MemStallM,
  output logic        AddrFaultM
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;

  logic [AW+1:0] addr_q;
  logic [31:0]   data_q;
  logic          write_q;
  logic          byte_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          direct;
  logic          do_access;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_data;
  logic          acc_write;
  logic          acc_byte;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          fault;
  logic [31:0]   mem_word;
  logic [7:0]    sel_byte;
  logic [31:0]   merged;
  logic [31:0]   wr_word;
  logic [31:0]   load_data;
  logic          mem_we;

  // Upper address bits only alias; they never select storage.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ALUOutM[31:AW+2];

  // Accesses that complete one cycle after acceptance skip BUSY and use the live request.
  assign direct = (LATENCY == 1) || (POSTED && MemWriteM);

  always_comb begin
    state_next = state;
    count_next = count;
    do_access  = 1'b0;
    acc_addr   = addr_q;
    acc_data   = data_q;
    acc_write  = write_q;
    acc_byte   = byte_q;
    case (state)
      IDLE: begin
        if (MemReqM) begin
          if (direct) begin
            state_next = DONE;
            do_access  = 1'b1;
            acc_addr   = ALUOutM[AW+1:0];
            acc_data   = WriteDataM;
            acc_write  = MemWriteM;
            acc_byte   = MByteM;
          end else begin
            state_next = BUSY;
            count_next = CW'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        count_next = count - 1'b1;
        if (count == CW'(1)) begin
          state_next = DONE;
          do_access  = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign idx      = acc_addr[AW+1:2];
  assign lane     = acc_addr[1:0];
  assign fault    = ~acc_byte & (lane != 2'b00);
  assign mem_word = mem[idx];
  assign sel_byte = mem_word[{lane, 3'b000} +: 8];

  // Byte stores rewrite one little-endian lane of the current word.
  always_comb begin
    merged = mem_word;
    merged[{lane, 3'b000} +: 8] = acc_data[7:0];
  end

  assign wr_word   = acc_byte ? merged : acc_data;
  assign load_data = fault ? 32'h0 : (acc_byte ? {24'h0, sel_byte} : mem_word);
  assign mem_we    = do_access & acc_write & ~fault;

  // Storage is deliberately not reset; a held reset also blocks any write.
  always_ff @(posedge clk) begin
    if (mem_we && reset) begin
      mem[idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      ReadData   <= '0;
      MemReadyM  <= 1'b0;
      AddrFaultM <= 1'b0;
    end else begin
      MemReadyM  <= do_access;
      AddrFaultM <= do_access & fault;
      if (state == IDLE && MemReqM) begin
        addr_q  <= ALUOutM[AW+1:0];
        data_q  <= WriteDataM;
        write_q <= MemWriteM;
        byte_q  <= MByteM;
      end
      if (do_access && !acc_write) begin
        ReadData <= load_data;
      end
    end
  end

  assign MemStallM = MemReqM & ~MemReadyM;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder; follows DMEM_POSTED_WRITE_EN when it is defined.
module tb_dmem_responder;

`ifdef DMEM_POSTED_WRITE_EN
  localparam int LAT    = 4;
  localparam bit POSTED = 1'b1;
`else
  localparam int LAT    = 2;
  localparam bit POSTED = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_flt;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        MemReqM;
  logic        MemWriteM;
  logic        MByteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadData;
  logic        MemReadyM;
  logic        MemStallM;
  logic        AddrFaultM;

  int          num_checks;
  int          num_fails;
  logic [31:0] hold_rd;
  vec_t        vecs[$];

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(LAT)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .MByteM     (MByteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadData   (ReadData),
    .MemReadyM  (MemReadyM),
    .MemStallM  (MemStallM),
    .AddrFaultM (AddrFaultM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic wr, input logic byt, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_flt);
    vec_t v;
    v.wr = wr; v.byt = byt; v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_flt = exp_flt;
    vecs.push_back(v);
  endtask

  // Called just after a rising edge with the DUT idle; returns just after a rising edge.
  task automatic applyStimulus(input vec_t v, input string name);
    logic [31:0] got_rd;
    logic        got_flt;
    int          lat;
    int          exp_lat;
    bit          seen;
    bit          stall_ok;
    bit          quiet_ok;
    MemReqM    = 1'b1;
    MemWriteM  = v.wr;
    MByteM     = v.byt;
    ALUOutM    = v.addr;
    WriteDataM = v.wdata;
    exp_lat    = (POSTED && v.wr) ? 1 : LAT;
    lat = 0; seen = 1'b0; stall_ok = 1'b1; got_rd = '0; got_flt = 1'b0;
    while (!seen && lat <= LAT + 3) begin
      @(negedge clk);
      if (MemReadyM) begin
        seen    = 1'b1;
        got_rd  = ReadData;
        got_flt = AddrFaultM;
        if (MemStallM) stall_ok = 1'b0;
      end else begin
        if (!MemStallM) stall_ok = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!seen) begin
      num_checks++;
      num_fails++;
      $display("[TB] FAIL %s timeout: no MemReadyM within %0d cycles, expected %0d", name, lat, exp_lat);
      MemReqM = 1'b0;
    end else begin
      checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({name, " ReadData"}, got_rd, v.exp_rd);
      checkOutput({name, " AddrFaultM"}, {31'h0, got_flt}, {31'h0, v.exp_flt});
      checkOutput({name, " MemStallM"}, {31'h0, stall_ok}, 32'h1);
      @(posedge clk); #1;
      MemReqM  = 1'b0;
      quiet_ok = 1'b1;
      for (int i = 0; i <= LAT; i++) begin
        @(negedge clk);
        if (MemReadyM || MemStallM || AddrFaultM) quiet_ok = 1'b0;
      end
      checkOutput({name, " quiet after DONE"}, {31'h0, quiet_ok}, 32'h1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    num_checks = 0;
    num_fails  = 0;
    hold_rd    = 32'h0;

    addVec(1'b1, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0);
    addVec(1'b0, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0);
    addVec(1'b1, 1'b0, 32'h010, 32'h11223344, 32'h0,        1'b0);
    addVec(1'b1, 1'b1, 32'h013, 32'hFFFFFFA5, 32'h0,        1'b0);
    addVec(1'b0, 1'b0, 32'h010, 32'h0,        32'hA5223344, 1'b0);
    addVec(1'b0, 1'b1, 32'h012, 32'h0,        32'h00000022, 1'b0);
    addVec(1'b0, 1'b1, 32'h013, 32'h0,        32'h000000A5, 1'b0);
    addVec(1'b1, 1'b1, 32'h011, 32'h0000007E, 32'h0,        1'b0);
    addVec(1'b0, 1'b0, 32'h010, 32'h0,        32'hA5227E44, 1'b0);
    addVec(1'b1, 1'b0, 32'h004, 32'hCAFEF00D, 32'h0,        1'b0);
    addVec(1'b0, 1'b0, 32'h006, 32'h0,        32'h00000000, 1'b1);
    addVec(1'b1, 1'b0, 32'h006, 32'h12345678, 32'h0,        1'b1);
    addVec(1'b0, 1'b0, 32'h004, 32'h0,        32'hCAFEF00D, 1'b0);
    addVec(1'b1, 1'b0, 32'h100, 32'h00000055, 32'h0,        1'b0);
    addVec(1'b0, 1'b0, 32'h000, 32'h0,        32'h00000055, 1'b0);
    addVec(1'b1, 1'b0, 32'h0FC, 32'h0BADF00D, 32'h0,        1'b0);
    addVec(1'b0, 1'b0, 32'h1FC, 32'h0,        32'h0BADF00D, 1'b0);
    addVec(1'b0, 1'b1, 32'h0FE, 32'h0,        32'h000000AD, 1'b0);
    addVec(1'b1, 1'b0, 32'h020, 32'h600DCAFE, 32'h0,        1'b0);
    addVec(1'b0, 1'b0, 32'h020, 32'h0,        32'h600DCAFE, 1'b0);

    // Reset held with a pending request: outputs cleared, stall follows the request.
    reset      = 1'b0;
    MemReqM    = 1'b1;
    MemWriteM  = 1'b1;
    MByteM     = 1'b0;
    ALUOutM    = 32'h10;
    WriteDataM = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ReadData", ReadData, 32'h0);
    checkOutput("reset MemReadyM", {31'h0, MemReadyM}, 32'h0);
    checkOutput("reset MemStallM", {31'h0, MemStallM}, 32'h1);
    checkOutput("reset AddrFaultM", {31'h0, AddrFaultM}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      if (v.wr) v.exp_rd = hold_rd;
      else      hold_rd  = v.exp_rd;
      applyStimulus(v, $sformatf("vec%0d", i));
    end

    if (!POSTED) begin
      vec_t v;
      bit   ready_seen;
      // Reset in the BUSY cycle of a store: no completion and no array write.
      MemReqM    = 1'b1;
      MemWriteM  = 1'b1;
      MByteM     = 1'b0;
      ALUOutM    = 32'h20;
      WriteDataM = 32'hBAD00BAD;
      @(posedge clk); #1;
      reset = 1'b0;
      ready_seen = 1'b0;
      @(negedge clk);
      if (MemReadyM) ready_seen = 1'b1;
      @(posedge clk); #1;
      MemReqM = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < LAT + 2; i++) begin
        @(negedge clk);
        if (MemReadyM) ready_seen = 1'b1;
      end
      checkOutput("abort MemReadyM", {31'h0, ready_seen}, 32'h0);
      checkOutput("abort ReadData cleared", ReadData, 32'h0);
      @(posedge clk); #1;
      v.wr = 1'b0; v.byt = 1'b0; v.addr = 32'h20; v.wdata = 32'h0;
      v.exp_rd = 32'h600DCAFE; v.exp_flt = 1'b0;
      applyStimulus(v, "abort reload");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
